// File: rtl/systolic_pe_array_if.sv
// Operand/result bundle for the 4x4 systolic MAC grid.
// master = skew stage side, slave = systolic_pe_array.
interface systolic_pe_array_if #(
    parameter int DATA_W = 8
);
    logic                             i_start;
    logic [3:0][6:0][DATA_W-1:0]      i_row;
    logic [3:0][6:0][DATA_W-1:0]      i_col;
    logic [3:0][3:0][DATA_W-1:0]      o_c;
    logic                             o_busy;
    logic                             o_validResult;

    modport master (
        output i_start, i_row, i_col,
        input  o_c, o_busy, o_validResult
    );

    modport slave (
        input  i_start, i_row, i_col,
        output o_c, o_busy, o_validResult
    );
endinterface

// File: rtl/systolic_pe_array.sv
// 4x4 output-stationary systolic MAC grid: captures pre-skewed operands, runs 10 steps, emits C = A x B.
// Optional macro SYSTOLIC_SATURATE_EN: wide accumulators, results clamp to 2^DATA_W-1.

module systolic_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [ACC_W-1:0]  acc_o
);
    logic [DATA_W-1:0] a_q, b_q;
    logic [ACC_W-1:0]  acc_q, acc_d;

    // Product is taken at accumulator width: truncates in the wrapping build.
    assign acc_d = acc_q + (ACC_W'(a_i) * ACC_W'(b_i));

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (clr_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (en_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;
endmodule

module systolic_pe_array #(
    parameter int DATA_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_arst,
    systolic_pe_array_if.slave   bus_if
);
    localparam int N = 4;
`ifdef SYSTOLIC_SATURATE_EN
    localparam int ACC_W = 2 * DATA_W + 2;
`else
    localparam int ACC_W = DATA_W;
`endif
    localparam logic [3:0] LAST_STEP = 4'd9;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                           state_q;
    logic [3:0]                       step_q;
    logic [N-1:0][6:0][DATA_W-1:0]    row_sr_q, col_sr_q;
    logic [N-1:0][N-1:0][DATA_W-1:0]  c_q, c_d;
    logic                             busy_q, valid_q;
    logic                             pe_clr, pe_en;

    // a_h[i][j] feeds PE(i,j) from the west; b_v[i][j] feeds it from the north.
    logic [N-1:0][N:0][DATA_W-1:0]    a_h;
    logic [N:0][N-1:0][DATA_W-1:0]    b_v;
    logic [N-1:0][N-1:0][ACC_W-1:0]   acc_w;
    logic                             edge_unused;

    assign pe_clr = (state_q == IDLE) && bus_if.i_start;
    assign pe_en  = (state_q == RUN);

    for (genvar i = 0; i < N; i++) begin : g_edge
        assign a_h[i][0] = row_sr_q[i][0];
        assign b_v[0][i] = col_sr_q[i][0];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .i_clk (i_clk),
                .i_arst(i_arst),
                .clr_i (pe_clr),
                .en_i  (pe_en),
                .a_i   (a_h[i][j]),
                .b_i   (b_v[i][j]),
                .a_o   (a_h[i][j+1]),
                .b_o   (b_v[i+1][j]),
                .acc_o (acc_w[i][j])
            );
        end
    end

    // East and south edge forwards leave the array and go nowhere.
    always_comb begin
        edge_unused = ^b_v[N];
        for (int i = 0; i < N; i++) edge_unused = edge_unused ^ (^a_h[i][N]);
    end

    always_comb begin
        c_d = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
`ifdef SYSTOLIC_SATURATE_EN
                c_d[i][j] = (|acc_w[i][j][ACC_W-1:DATA_W]) ? '1 : acc_w[i][j][DATA_W-1:0];
`else
                c_d[i][j] = acc_w[i][j];
`endif
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q  <= IDLE;
            step_q   <= '0;
            row_sr_q <= '0;
            col_sr_q <= '0;
            c_q      <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus_if.i_start) begin
                        row_sr_q <= bus_if.i_row;
                        col_sr_q <= bus_if.i_col;
                        step_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    // Slot 0 is consumed this step; zeros backfill so steps 7..9 inject zero.
                    for (int r = 0; r < N; r++) begin
                        row_sr_q[r] <= {DATA_W'(0), row_sr_q[r][6:1]};
                        col_sr_q[r] <= {DATA_W'(0), col_sr_q[r][6:1]};
                    end
                    if (step_q == LAST_STEP) state_q <= DONE;
                    else                     step_q  <= step_q + 4'd1;
                end
                DONE: begin
                    c_q     <= c_d;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_if.o_c           = c_q;
    assign bus_if.o_busy        = busy_q;
    assign bus_if.o_validResult = valid_q;
endmodule
